// File: rtl/modulo_unit.sv
// modulo_unit: iterative remainder engine (rest = a mod b) for the GCD datapath.
// Restoring shift-subtract, one dividend bit per clock. Level-started: the
// controller holds start_i through the whole operation, so the unit waits in
// DONE until start_i drops before it can accept a new request.
module modulo_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] rest_o,
  output logic             busy_o,
  output logic             div_zero_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] dvd_q;   // dividend, shifted out MSB first
  logic [WIDTH-1:0] dvs_q;   // latched divisor
  logic [WIDTH-1:0] rem_q;   // partial remainder; always < dvs so WIDTH bits hold it
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rest_q;
  logic             dz_q;

  logic [WIDTH:0]   t;       // shifted-in trial value, one bit wider than the divisor
  logic             ge;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] rem_d;

  // Restoring step: shift in next dividend bit, subtract divisor if it fits.
  // The compare is WIDTH+1 bits so a full-scale divisor cannot overflow. When
  // t >= dvs the true difference is < dvs < 2^WIDTH, so the low WIDTH bits
  // of the subtraction are exact.
  always_comb begin
    t     = {rem_q, dvd_q[WIDTH-1]};
    ge    = (t >= {1'b0, dvs_q});
    diff  = t[WIDTH-1:0] - dvs_q;
    rem_d = ge ? diff : t[WIDTH-1:0];
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      rest_q  <= '0;
      dz_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            dvd_q <= a_i;
            dvs_q <= b_i;
            rem_q <= '0;
            cnt_q <= CW'(WIDTH - 1);
            if (b_i == '0) begin
              rest_q  <= a_i;
              dz_q    <= 1'b1;
              state_q <= DONE;
            end else begin
              dz_q    <= 1'b0;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= rem_d;
          dvd_q <= dvd_q << 1;
          if (cnt_q == '0) begin
            rest_q  <= rem_d;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          // Re-arm only once the request level has dropped.
          if (!start_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready_o    = (state_q == DONE);
  assign busy_o     = (state_q == CALC);
  assign rest_o     = rest_q;
  assign div_zero_o = dz_q;

endmodule

// File: tb/tb_modulo_unit.sv
// tb_modulo_unit: randomized and directed checks of modulo_unit against a
// plain-arithmetic remainder model and a level-start controller model.
module tb_modulo_unit;

  localparam int W = 16;

  logic         gclk;
  logic         rst_n;
  logic         start_i;
  logic [W-1:0] a_i, b_i;
  logic         ready_o, busy_o, div_zero_o;
  logic [W-1:0] rest_o;

  int n_tests = 0;
  int n_fail  = 0;

  modulo_unit #(.WIDTH(W)) dut (
    .clk        (gclk),
    .rst_n_i    (rst_n),
    .start_i    (start_i),
    .a_i        (a_i),
    .b_i        (b_i),
    .ready_o    (ready_o),
    .rest_o     (rest_o),
    .busy_o     (busy_o),
    .div_zero_o (div_zero_o)
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_mod(input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == '0) ? a : (a % b);
  endfunction

  // One controller transaction: raise start with operands, scramble the
  // operand inputs after the start edge, wait for ready, then hold start for
  // one cycle (controller write state) plus 'hold' extra cycles, then drop it.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold, output logic [W-1:0] got);
    logic [W-1:0] exp_r;
    int lat, nbusy, ready_cnt;
    exp_r = ref_mod(a, b);
    @(negedge gclk);
    a_i = a; b_i = b; start_i = 1'b1;
    lat = 0; nbusy = 0;
    for (int c = 1; c <= 3 * W; c++) begin
      @(posedge gclk); #1;
      a_i = W'($urandom); b_i = W'($urandom);
      if (busy_o) nbusy++;
      if (ready_o) begin lat = c; break; end
    end
    chk("latency", lat, (b == '0) ? 1 : W + 1);
    chk("busy_cycles", nbusy, (b == '0) ? 0 : W);
    chk("rest", rest_o, exp_r);
    chk("div_zero", div_zero_o, (b == '0));
    got = rest_o;
    ready_cnt = 1;
    for (int k = 0; k < 1 + hold; k++) begin
      @(posedge gclk); #1;
      if (ready_o) ready_cnt++;
      chk("hold_busy", busy_o, 0);
      chk("hold_rest", rest_o, exp_r);
    end
    chk("ready_cycles", ready_cnt, 2 + hold);
    start_i = 1'b0;
    @(posedge gclk); #1;
    chk("idle_ready", ready_o, 0);
    chk("idle_busy", busy_o, 0);
    chk("idle_rest", rest_o, exp_r);
  endtask

  initial begin
    logic [W-1:0] got, x, y, r;
    rst_n = 1'b0; start_i = 1'b1; a_i = 16'd48; b_i = 16'd18;

    // Reset held with start high: everything stays cleared.
    repeat (3) @(posedge gclk);
    #1;
    chk("rst_ready", ready_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_dz", div_zero_o, 0);
    chk("rst_rest", rest_o, 0);
    @(negedge gclk);
    start_i = 1'b0; rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge gclk); #1;
      chk("idle_after_rst", {ready_o, busy_o}, 0);
    end

    // Basic and boundary cases.
    run_op(16'd48, 16'd18, 0, got);
    run_op(16'hFFFF, 16'hFFFF, 0, got);
    run_op(16'hFFFF, 16'd1, 0, got);
    run_op(16'd5, 16'hFFFF, 0, got);
    run_op(16'hFFFF, 16'h8000, 0, got);
    run_op(16'd0, 16'd7, 0, got);
    run_op(16'd37, 16'd0, 0, got);

    // Start held 5 cycles past the controller handshake: no re-run.
    run_op(16'd1000, 16'd7, 5, got);

    // Asynchronous reset between edges in CALC cycle 7.
    @(negedge gclk);
    a_i = 16'd50000; b_i = 16'd3; start_i = 1'b1;
    repeat (8) @(posedge gclk);
    #2;
    chk("calc_busy_pre_rst", busy_o, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_ready", ready_o, 0);
    chk("abort_busy", busy_o, 0);
    chk("abort_rest", rest_o, 0);
    chk("abort_dz", div_zero_o, 0);
    start_i = 1'b0;
    @(negedge gclk);
    rst_n = 1'b1;
    run_op(16'd50000, 16'd3, 0, got);

    // GCD chain driven by the remainders the DUT returns.
    x = 16'd1071; y = 16'd462;
    for (int s = 0; s < 10 && y != 0; s++) begin
      run_op(x, y, 0, r);
      x = y; y = r;
    end
    chk("gcd_result", x, 21);

    // Random operands, with small, full-range and zero divisors mixed in.
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      case ($urandom_range(0, 3))
        0: rb = W'($urandom_range(1, 20));
        1: rb = '0;
        default: rb = W'($urandom);
      endcase
      run_op(ra, rb, $urandom_range(0, 2), got);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound so the bench can never hang.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/modulo_unit.md
Name: modulo_unit

Overview:
- Iterative remainder engine (rest = a mod b) for the GCD datapath.
- Sits directly downstream of the GCD controller: it consumes the controller's modulo_start and operands, and returns modulo_ready plus the remainder.
- Uses a restoring shift-subtract algorithm, one quotient bit per clock.
- The controller holds start high for the whole calc state, so the unit is level-started and requires start to drop before it re-arms.

Parameters:
- WIDTH, 16, operand and result width in bits.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n_i  input  1  asynchronous active-low reset.
- start_i  input  1  level request from controller (modulo_start_o).
- a_i  input  WIDTH  dividend (ALU operand A).
- b_i  input  WIDTH  divisor (ALU operand B).
- ready_o  output  1  result valid; connects to controller modulo_ready_i.
- rest_o  output  WIDTH  remainder a mod b.
- busy_o  output  1  high while iterating.
- div_zero_o  output  1  high with ready_o when latched b was 0.

Behaviour:
- Reset (async, rst_n_i=0): state=IDLE; ready_o=0, busy_o=0, div_zero_o=0, rest_o=0; internal shift register, remainder and counter cleared.
  - Reset asserted mid-operation aborts immediately; no ready_o follows.
- States: IDLE, CALC, DONE.
- IDLE:
  - start_i=1 at a clock edge latches a_i into the dividend shift register (dvd) and b_i into the divisor register (dvs).
  - Clears rem (WIDTH+1 bits) and loads cnt=WIDTH-1.
  - If b_i==0: go directly to DONE with rest_o<=a_i, div_zero_o<=1.
  - Otherwise go to CALC with div_zero_o<=0.
- CALC, per cycle:
  - t = {rem[WIDTH-1:0], dvd[WIDTH-1]}.
  - If t >= {1'b0,dvs}: rem<=t-dvs; else rem<=t.
  - dvd<=dvd<<1.
  - If cnt==0: go to DONE and load rest_o with the final rem[WIDTH-1:0]; else cnt<=cnt-1.
  - The compare is unsigned and WIDTH+1 bits wide, so no overflow at the maximum divisor.
- DONE:
  - ready_o=1; rest_o and div_zero_o stable.
  - Leave to IDLE on the first edge where start_i=0.
  - While start_i stays 1, remain in DONE; never restart on the same start level.
- Outputs:
  - ready_o is a registered state decode, high exactly while in DONE.
  - busy_o is high exactly while in CALC.
- Latency: start edge in IDLE to ready_o high = WIDTH+1 clocks for b!=0, and 1 clock for b==0.
- Operands are sampled only at the start edge; changes on a_i/b_i during CALC/DONE are ignored.
- start_i is ignored during CALC; a drop mid-CALC does not abort. The unit then finishes and holds DONE for one cycle before returning to IDLE.
- rest_o keeps its last value in IDLE until the next operation completes.
- Controller handshake: the controller sees ready_o, advances to its write state and drops start the next cycle, so ready_o is high for 2 cycles. The controller captures rest_o on its first cycle; rest_o is unchanged in the second.
- a<b yields rest=a; a==b yields rest=0; a=0 yields rest=0.

Test Plan:
- Reset & idle: hold rst_n_i=0 with start_i=1 -> all outputs 0. Release with start_i=0 -> stays IDLE and ready_o=0 indefinitely.
- Basic (WIDTH=16): a=48, b=18, start held -> busy_o for 16 cycles, ready_o on the 17th edge, rest_o=12, div_zero_o=0. Drop start -> IDLE the next edge, rest_o holds 12.
- Boundaries:
  - a=0xFFFF, b=0xFFFF -> rest 0.
  - a=0xFFFF, b=1 -> rest 0.
  - a=5, b=0xFFFF -> rest 5.
  - a=0xFFFF, b=0x8000 -> rest 0x7FFF.
  - a=0, b=7 -> rest 0.
- Divide by zero: a=37, b=0 -> ready_o one edge after start, rest_o=37, div_zero_o=1, busy_o never high.
- Level-start and robustness:
  - Keep start high 5 cycles after ready -> exactly one result, no re-run.
  - Change a_i/b_i mid-CALC -> result uses the latched values.
  - Assert rst_n_i=0 asynchronously (between edges) in CALC cycle 7 -> outputs 0 immediately, and the next start computes correctly.
- GCD chain with controller model: a=1071, b=462 -> remainders 147, 21, 0 in successive operations, each meeting the WIDTH+1 latency, ready_o high exactly 2 cycles per operation.
